divider: RTL

- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions. It is the subtract-based counterpart of the combinational adder.
- Sits beside the ALU in the execute stage. The pipeline stalls on `busy` and collects the result when `done` pulses.
- Computes one quotient bit per clock. Divide-by-zero and signed-overflow cases are resolved in a single cycle.

---
 rtl/divider.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per clock; divide-by-zero and signed overflow finish in one cycle.
module divider #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [XLEN-1:0]  result_q, result_d;

    // Datapath registers carry no reset; they are always reloaded on accept.
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  div_q, div_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             sel_rem_q, sel_rem_d;

    logic             accept;
    logic             signed_op;
    logic             div_zero;
    logic             overflow;
    logic             special;
    logic             last_iter;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    trial;

    function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] x);
        logic signed [XLEN-1:0] neg;
        neg = -x;
        return x[XLEN-1] ? $unsigned(neg) : $unsigned(x);
    endfunction

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] x, input logic neg);
        return neg ? (~x + {{(XLEN-1){1'b0}}, 1'b1}) : x;
    endfunction

    assign accept    = start && (state_q == S_IDLE);
    assign signed_op = ~op[0];
    assign div_zero  = (b == '0);
    assign overflow  = signed_op && (a == MIN_NEG) && (b == '1);
    assign special   = div_zero || overflow;
    assign last_iter = (state_q == S_CALC) && (cnt_q == CNT_W'(XLEN-1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Next-state logic. S_DONE is the single finishing cycle that signs and
    // selects the answer; done is registered out of it one edge later.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = special ? S_DONE : S_CALC;
                    cnt_d   = '0;
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic
    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = done_q;
        result   = result_q;
        done_d   = 1'b0;
        result_d = result_q;
        if (state_q == S_DONE) begin
            done_d   = 1'b1;
            result_d = sel_rem_q ? cond_neg(rem_q, r_neg_q) : cond_neg(quo_q, q_neg_q);
        end
    end

    // Iteration step: shift {rem,quo} left and trial-subtract the divisor in XLEN+1 bits.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        trial   = shifted - {1'b0, div_q};
    end

    always_comb begin
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        sel_rem_d = sel_rem_q;
        if (accept) begin
            sel_rem_d = op[1];
            div_d     = b;
            if (div_zero) begin
                // Preload the architectural answers so S_DONE needs no special path.
                quo_d   = '1;
                rem_d   = a;
                q_neg_d = 1'b0;
                r_neg_d = 1'b0;
            end else if (overflow) begin
                quo_d   = MIN_NEG;
                rem_d   = '0;
                q_neg_d = 1'b0;
                r_neg_d = 1'b0;
            end else begin
                quo_d   = signed_op ? abs_val(a) : a;
                div_d   = signed_op ? abs_val(b) : b;
                rem_d   = '0;
                q_neg_d = signed_op && (a[XLEN-1] ^ b[XLEN-1]);
                r_neg_d = signed_op && a[XLEN-1];
            end
        end else if (state_q == S_CALC) begin
            if (!trial[XLEN]) begin
                rem_d = trial[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d = shifted[XLEN-1:0];
                quo_d = {quo_q[XLEN-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        rem_q     <= rem_d;
        quo_q     <= quo_d;
        div_q     <= div_d;
        q_neg_q   <= q_neg_d;
        r_neg_q   <= r_neg_d;
        sel_rem_q <= sel_rem_d;
    end

endmodule
